// File: rtl/iecdrv_rom_pkg.sv
// Shared types and helpers for the multi-drive ROM read scheduler.
// Contents: ROM size codes, FSM state enum, read-pipe payload struct and
// the address mask applied when a client read is issued.
package iecdrv_rom_pkg;

    localparam int unsigned MAX_CLIENTS = 8;
    localparam int unsigned IDX_W       = 3;

    localparam logic [1:0] ROMSZ_8K  = 2'b00;
    localparam logic [1:0] ROMSZ_16K = 2'b01;
    localparam logic [1:0] ROMSZ_32K = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // One in-flight read: which client it belongs to and which image it came from.
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic             sel;
    } pipe_entry_t;

    // Custom images mirror down to their real size; the std image is 16K.
    function automatic logic [14:0] rom_mask(input logic [14:0] addr,
                                             input logic [1:0]  sz,
                                             input logic        sel);
        logic [14:0] m;
        m = addr;
        if (sel) begin
            m[14] = addr[14] & sz[1];
            m[13] = addr[13] & sz[0];
        end else begin
            m[14] = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/iecdrv_rom_pipe.sv
// RDLAT-deep shift register that tracks outstanding ROM reads so each
// returned byte is steered to its client with the image select it was issued with.
// Ports: clk, reset (sync, high), flush (sync, drops all in-flight reads),
//        in_entry (read issued this cycle), out_entry (read returning this cycle).
module iecdrv_rom_pipe
    import iecdrv_rom_pkg::*;
#(
    parameter int unsigned RDLAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  pipe_entry_t in_entry,
    output pipe_entry_t out_entry
);

    pipe_entry_t stage [RDLAT];

    // Shift one stage per cycle; flush clears every stage including the push slot.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < int'(RDLAT); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= in_entry;
            for (int i = 1; i < int'(RDLAT); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_entry = stage[RDLAT-1];

endmodule

// File: rtl/iecdrv_rom_share.sv
// Time-division ROM read scheduler for NCLIENT drive CPUs sharing one or two ROMs.
// Each ph2_f strobe starts a frame issuing one masked read per client in index
// order; each returned byte lands in that client's data register.
// Ports: clk, reset (sync, high), ph2_f (frame strobe), rom_sz (custom ROM size),
//        rom_sel (per-client image), cl_addr (packed addresses), cl_data/cl_valid
//        (packed returned bytes + update pulses), mem_addr/mem_sel (ROM request),
//        mem_q0/mem_q1 (std/custom ROM data), busy, overrun (sticky).
module iecdrv_rom_share
    import iecdrv_rom_pkg::*;
#(
    parameter int unsigned NCLIENT = 4,
    parameter int unsigned AW      = 15,
    parameter int unsigned DW      = 8,
    parameter int unsigned RDLAT   = 1,
    parameter int unsigned NROM    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ph2_f,
    input  logic [1:0]            rom_sz,
    input  logic [NCLIENT-1:0]    rom_sel,
    input  logic [NCLIENT*AW-1:0] cl_addr,
    output logic [NCLIENT*DW-1:0] cl_data,
    output logic [NCLIENT-1:0]    cl_valid,
    output logic [AW-1:0]         mem_addr,
    output logic                  mem_sel,
    input  logic [DW-1:0]         mem_q0,
    input  logic [DW-1:0]         mem_q1,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned DCW = 2;

    state_e           state;
    logic [IDX_W-1:0] slot;
    logic [DCW-1:0]   drain_cnt;

    logic             final_drain_c;
    logic             restart_c;
    logic             issue_c;
    logic [AW-1:0]    slot_addr_c;
    logic             slot_sel_c;
    logic [14:0]      masked_c;
    pipe_entry_t      push_c;
    pipe_entry_t      ret_c;

    // Current-slot address/select mux and issue/restart decode.
    always_comb begin
        final_drain_c = (state == ST_DRAIN) && (drain_cnt == DCW'(RDLAT - 1));
        // ph2_f on the last drain cycle is a clean back-to-back frame, not an overrun.
        restart_c     = ph2_f && (state != ST_IDLE) && !final_drain_c;
        issue_c       = (state == ST_ISSUE) && !restart_c;

        slot_addr_c = '0;
        slot_sel_c  = 1'b0;
        for (int k = 0; k < int'(NCLIENT); k++) begin
            if (slot == IDX_W'(k)) begin
                slot_addr_c = cl_addr[k*AW +: AW];
                slot_sel_c  = rom_sel[k];
            end
        end
        if (NROM < 2) begin
            slot_sel_c = 1'b0;
        end
        masked_c = rom_mask(slot_addr_c[14:0], rom_sz, slot_sel_c);

        push_c       = '0;
        push_c.valid = issue_c;
        push_c.idx   = slot;
        push_c.sel   = slot_sel_c;
    end

    iecdrv_rom_pipe #(
        .RDLAT (RDLAT)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .flush     (restart_c),
        .in_entry  (push_c),
        .out_entry (ret_c)
    );

    // Frame FSM, ROM request registers and per-client capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            slot      <= '0;
            drain_cnt <= '0;
            mem_addr  <= '0;
            mem_sel   <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            cl_data   <= {(NCLIENT*DW){1'b1}};
            cl_valid  <= '0;
        end else begin
            cl_valid <= '0;

            // A returning read is dropped if an overrun restart happens on the same edge.
            if (ret_c.valid && !restart_c) begin
                for (int k = 0; k < int'(NCLIENT); k++) begin
                    if (ret_c.idx == IDX_W'(k)) begin
                        cl_data[k*DW +: DW] <= ret_c.sel ? mem_q1 : mem_q0;
                        cl_valid[k]         <= 1'b1;
                    end
                end
            end

            if (issue_c) begin
                mem_addr <= AW'(masked_c);
                mem_sel  <= slot_sel_c;
            end

            case (state)
                ST_IDLE: begin
                    if (ph2_f) begin
                        state <= ST_ISSUE;
                        slot  <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (restart_c) begin
                        slot    <= '0;
                        overrun <= 1'b1;
                    end else if (slot == IDX_W'(NCLIENT - 1)) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        slot <= slot + IDX_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (restart_c) begin
                        state   <= ST_ISSUE;
                        slot    <= '0;
                        overrun <= 1'b1;
                    end else if (final_drain_c) begin
                        if (ph2_f) begin
                            state <= ST_ISSUE;
                            slot  <= '0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iecdrv_rom_share.sv
// Directed bench for iecdrv_rom_share: three configurations share one stimulus
// stream (A: 4 clients RDLAT 1, B: 4 clients RDLAT 3, C: 1 client single ROM RDLAT 2).
module tb_iecdrv_rom_share;

    logic        clk = 1'b0;
    logic        reset;
    logic        ph2_f;
    logic [1:0]  rom_sz;
    logic [3:0]  rom_sel;
    logic [59:0] cl_addr;
    logic        rom_mode;

    logic [31:0] cl_data_a, cl_data_b;
    logic [7:0]  cl_data_c;
    logic [3:0]  cl_valid_a, cl_valid_b;
    logic        cl_valid_c;
    logic [14:0] mem_addr_a, mem_addr_b, mem_addr_c;
    logic        mem_sel_a, mem_sel_b, mem_sel_c;
    logic [7:0]  mem_q0_a, mem_q1_a, mem_q0_b, mem_q1_b, mem_q0_c, mem_q1_c;
    logic        busy_a, busy_b, busy_c;
    logic        overrun_a, overrun_b, overrun_c;

    logic [14:0] a_b1, a_b2, a_c1;

    int n_cmp  = 0;
    int n_fail = 0;
    int cnt_a [4];
    int cnt_b [4];
    int cnt_c;

    always #5 clk = ~clk;

    // ROM images: mode 0 returns the address low byte (custom: inverted), mode 1 fixed bytes.
    function automatic logic [7:0] romf(input logic [14:0] a, input logic img, input logic mode);
        if (mode) return img ? 8'h55 : 8'hAA;
        return img ? ~a[7:0] : a[7:0];
    endfunction

    // Address delay lines so each ROM model honours its configuration's read latency.
    always @(posedge clk) begin
        a_b1 <= mem_addr_b;
        a_b2 <= a_b1;
        a_c1 <= mem_addr_c;
    end

    assign mem_q0_a = romf(mem_addr_a, 1'b0, rom_mode);
    assign mem_q1_a = romf(mem_addr_a, 1'b1, rom_mode);
    assign mem_q0_b = romf(a_b2, 1'b0, rom_mode);
    assign mem_q1_b = romf(a_b2, 1'b1, rom_mode);
    assign mem_q0_c = romf(a_c1, 1'b0, rom_mode);
    assign mem_q1_c = romf(a_c1, 1'b1, rom_mode);

    iecdrv_rom_share #(.NCLIENT(4), .AW(15), .DW(8), .RDLAT(1), .NROM(2)) dut_a (
        .clk(clk), .reset(reset), .ph2_f(ph2_f), .rom_sz(rom_sz), .rom_sel(rom_sel),
        .cl_addr(cl_addr), .cl_data(cl_data_a), .cl_valid(cl_valid_a),
        .mem_addr(mem_addr_a), .mem_sel(mem_sel_a), .mem_q0(mem_q0_a), .mem_q1(mem_q1_a),
        .busy(busy_a), .overrun(overrun_a));

    iecdrv_rom_share #(.NCLIENT(4), .AW(15), .DW(8), .RDLAT(3), .NROM(2)) dut_b (
        .clk(clk), .reset(reset), .ph2_f(ph2_f), .rom_sz(rom_sz), .rom_sel(rom_sel),
        .cl_addr(cl_addr), .cl_data(cl_data_b), .cl_valid(cl_valid_b),
        .mem_addr(mem_addr_b), .mem_sel(mem_sel_b), .mem_q0(mem_q0_b), .mem_q1(mem_q1_b),
        .busy(busy_b), .overrun(overrun_b));

    iecdrv_rom_share #(.NCLIENT(1), .AW(15), .DW(8), .RDLAT(2), .NROM(1)) dut_c (
        .clk(clk), .reset(reset), .ph2_f(ph2_f), .rom_sz(rom_sz), .rom_sel(rom_sel[0:0]),
        .cl_addr(cl_addr[14:0]), .cl_data(cl_data_c), .cl_valid(cl_valid_c),
        .mem_addr(mem_addr_c), .mem_sel(mem_sel_c), .mem_q0(mem_q0_c), .mem_q1(mem_q1_c),
        .busy(busy_c), .overrun(overrun_c));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_count();
        tick();
        for (int k = 0; k < 4; k++) begin
            cnt_a[k] += int'(cl_valid_a[k]);
            cnt_b[k] += int'(cl_valid_b[k]);
        end
        cnt_c += int'(cl_valid_c);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Leaves the bench 1 time unit after the edge that samples ph2_f (cycle index 0).
    task automatic frame_start();
        ph2_f = 1'b1;
        tick();
        ph2_f = 1'b0;
    endtask

    // Expected one-hot valid for a frame: client k pulses after edge 1+k+rdlat.
    function automatic logic [3:0] exp_valid(input int c, input int n, input int r);
        if (c >= 1 + r && c <= n + r) return 4'(1 << (c - 1 - r));
        return 4'h0;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        ph2_f    = 1'b0;
        rom_sz   = 2'b00;
        rom_sel  = 4'b0000;
        rom_mode = 1'b0;
        cl_addr  = {15'h0103, 15'h0102, 15'h0101, 15'h0100};
        wait_ticks(3);
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_data_a",  64'(cl_data_a), 64'(32'hFFFF_FFFF));
        check("rst_data_c",  64'(cl_data_c), 64'(8'hFF));
        check("rst_valid_a", 64'(cl_valid_a), 64'(4'h0));
        check("rst_addr_a",  64'(mem_addr_a), 64'(15'h0000));
        check("rst_sel_a",   64'(mem_sel_a), 64'(1'b0));
        check("rst_busy_a",  64'(busy_a), 64'(1'b0));
        check("rst_ovr_a",   64'(overrun_a), 64'(1'b0));

        // Basic frame timing on all three configurations
        frame_start();
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) tick();
            check($sformatf("t1_valid_a_c%0d", c), 64'(cl_valid_a), 64'(exp_valid(c, 4, 1)));
            check($sformatf("t1_busy_a_c%0d", c),  64'(busy_a),     64'(c < 5));
            check($sformatf("t1_valid_b_c%0d", c), 64'(cl_valid_b), 64'(exp_valid(c, 4, 3)));
            check($sformatf("t1_busy_b_c%0d", c),  64'(busy_b),     64'(c < 7));
            check($sformatf("t1_valid_c_c%0d", c), 64'(cl_valid_c), 64'(exp_valid(c, 1, 2)));
            check($sformatf("t1_busy_c_c%0d", c),  64'(busy_c),     64'(c < 3));
        end
        check("t1_data_a", 64'(cl_data_a), 64'(32'h0302_0100));
        check("t1_data_b", 64'(cl_data_b), 64'(32'h0302_0100));
        check("t1_data_c", 64'(cl_data_c), 64'(8'h00));
        check("t1_hold_addr_a", 64'(mem_addr_a), 64'(15'h0103));

        // Address masking and custom-image capture
        rom_sz  = 2'b00;
        rom_sel = 4'b0010;
        cl_addr = {15'h0034, 15'h0012, 15'h7FFF, 15'h7FFF};
        frame_start();
        tick();
        check("t2_std_addr", 64'(mem_addr_a), 64'(15'h3FFF));
        check("t2_std_sel",  64'(mem_sel_a),  64'(1'b0));
        tick();
        check("t2_8k_addr",  64'(mem_addr_a), 64'(15'h1FFF));
        check("t2_8k_sel",   64'(mem_sel_a),  64'(1'b1));
        wait_ticks(6);
        check("t2_data_a", 64'(cl_data_a), 64'(32'h3412_00FF));
        rom_sz = 2'b11;
        frame_start();
        wait_ticks(2);
        check("t2_32k_addr", 64'(mem_addr_a), 64'(15'h7FFF));
        wait_ticks(6);
        rom_sz = 2'b01;
        frame_start();
        wait_ticks(2);
        check("t2_16k_addr", 64'(mem_addr_a), 64'(15'h3FFF));
        wait_ticks(6);

        // Mixed images with deep latency: select must travel with each read
        rom_mode = 1'b1;
        rom_sel  = 4'b1010;
        frame_start();
        wait_ticks(8);
        check("t3_data_b", 64'(cl_data_b), 64'(32'h55AA_55AA));
        check("t3_data_a", 64'(cl_data_a), 64'(32'h55AA_55AA));

        // Overrun: second strobe three cycles after the first
        rom_mode = 1'b0;
        rom_sel  = 4'b0000;
        cl_addr  = {15'h0103, 15'h0102, 15'h0101, 15'h0100};
        for (int k = 0; k < 4; k++) begin
            cnt_a[k] = 0;
            cnt_b[k] = 0;
        end
        cnt_c = 0;
        frame_start();
        tick_count();
        tick_count();
        ph2_f = 1'b1;
        tick_count();
        ph2_f = 1'b0;
        tick_count();
        check("t4_aborted_keep", 64'(cl_data_a[15:0]), 64'(16'h5500));
        for (int i = 0; i < 10; i++) tick_count();
        check("t4_ovr_a", 64'(overrun_a), 64'(1'b1));
        check("t4_ovr_b", 64'(overrun_b), 64'(1'b1));
        check("t4_ovr_c_b2b", 64'(overrun_c), 64'(1'b0));
        check("t4_cnt_a0", 64'(cnt_a[0]), 64'(2));
        check("t4_cnt_a1", 64'(cnt_a[1]), 64'(1));
        check("t4_cnt_a2", 64'(cnt_a[2]), 64'(1));
        check("t4_cnt_a3", 64'(cnt_a[3]), 64'(1));
        check("t4_cnt_b0", 64'(cnt_b[0]), 64'(1));
        check("t4_cnt_b3", 64'(cnt_b[3]), 64'(1));
        check("t4_cnt_c",  64'(cnt_c), 64'(2));
        check("t4_data_a", 64'(cl_data_a), 64'(32'h0302_0100));

        // Reset in the middle of a frame, then a strobe held under reset
        frame_start();
        wait_ticks(2);
        reset = 1'b1;
        tick();
        check("t5_data_a",  64'(cl_data_a), 64'(32'hFFFF_FFFF));
        check("t5_valid_a", 64'(cl_valid_a), 64'(4'h0));
        check("t5_busy_a",  64'(busy_a), 64'(1'b0));
        check("t5_ovr_a",   64'(overrun_a), 64'(1'b0));
        check("t5_data_b",  64'(cl_data_b), 64'(32'hFFFF_FFFF));
        ph2_f = 1'b1;
        tick();
        ph2_f = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("t5_nofrm_busy_%0d", i), 64'(busy_a), 64'(1'b0));
            check($sformatf("t5_nofrm_valid_%0d", i), 64'(cl_valid_a), 64'(4'h0));
        end

        // Single-ROM configuration never selects the custom image
        rom_sz  = 2'b11;
        rom_sel = 4'b1111;
        cl_addr = {15'h0103, 15'h0102, 15'h0101, 15'h0042};
        frame_start();
        tick();
        check("t6_sel_c",  64'(mem_sel_c),  64'(1'b0));
        check("t6_addr_c", 64'(mem_addr_c), 64'(15'h0042));
        check("t6_sel_a",  64'(mem_sel_a),  64'(1'b1));
        wait_ticks(7);
        check("t6_data_c",  64'(cl_data_c), 64'(8'h42));
        check("t6_data_a0", 64'(cl_data_a[7:0]), 64'(8'hBD));
        check("t6_sel_b",   64'(mem_sel_b), 64'(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
